// File: rtl/alu_structure_pkg.sv
// rtl/alu_structure_pkg.sv - shared types and constants for the multiply/divide unit
package alu_structure_pkg;

  localparam int MD_WIDTH = 32;

  // Encodings follow the MIPS funct field so decode can pass funct straight through
  typedef enum logic [5:0] {
    MD_MTHI  = 6'h11,
    MD_MTLO  = 6'h13,
    MD_MULT  = 6'h18,
    MD_MULTU = 6'h19,
    MD_DIV   = 6'h1A,
    MD_DIVU  = 6'h1B
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUL   = 2'd1,
    S_DIV   = 2'd2,
    S_FIXUP = 2'd3
  } md_state_t;

endpackage

// File: rtl/alu_muldiv_unit_if.sv
// rtl/alu_muldiv_unit_if.sv - command/result bundle between EX stage and the multiply/divide unit
interface alu_muldiv_unit_if #(
  parameter int WIDTH = alu_structure_pkg::MD_WIDTH
);
  import alu_structure_pkg::*;

  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             EX_Stall;
  logic             EX_Flush;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             busy;
  logic             done;

  modport master (
    output start, op, A, B, EX_Stall, EX_Flush,
    input  HI, LO, busy, done
  );

  modport slave (
    input  start, op, A, B, EX_Stall, EX_Flush,
    output HI, LO, busy, done
  );

endinterface

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - one shift-add / restoring-subtract step plus final sign fixup
module muldiv_datapath
  import alu_structure_pkg::*;
#(
  parameter int               WIDTH     = MD_WIDTH,
  parameter logic [WIDTH-1:0] DIV0_QUOT = {WIDTH{1'b1}}
) (
  input  logic             is_div_i,
  input  logic             div0_i,
  input  logic             neg_res_i,
  input  logic             neg_a_i,
  input  logic [WIDTH-1:0] acc_hi_i,
  input  logic [WIDTH-1:0] acc_lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] step_hi_o,
  output logic [WIDTH-1:0] step_lo_o,
  output logic [WIDTH-1:0] fix_hi_o,
  output logic [WIDTH-1:0] fix_lo_o
);

  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   prod_neg;

  // One iteration: multiply shifts the sum right into LO; divide shifts the dividend left into the remainder
  always_comb begin
    mul_sum   = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi_i, acc_lo_i[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_i};
    if (is_div_i) begin
      // Top bit set means the trial subtraction went negative: restore
      if (div_diff[WIDTH]) begin
        step_hi_o = div_shift[WIDTH-1:0];
        step_lo_o = {acc_lo_i[WIDTH-2:0], 1'b0};
      end else begin
        step_hi_o = div_diff[WIDTH-1:0];
        step_lo_o = {acc_lo_i[WIDTH-2:0], 1'b1};
      end
    end else begin
      step_hi_o = mul_sum[WIDTH:1];
      step_lo_o = {mul_sum[0], acc_lo_i[WIDTH-1:1]};
    end
  end

  // Final HI/LO: re-apply signs to magnitude results; divide-by-zero keeps the raw dividend in acc_lo
  always_comb begin
    prod     = {acc_hi_i, acc_lo_i};
    prod_neg = -prod;
    if (is_div_i && div0_i) begin
      fix_hi_o = acc_lo_i;
      fix_lo_o = DIV0_QUOT;
    end else if (is_div_i) begin
      fix_lo_o = neg_res_i ? -acc_lo_i : acc_lo_i;
      fix_hi_o = neg_a_i ? -acc_hi_i : acc_hi_i;
    end else begin
      {fix_hi_o, fix_lo_o} = neg_res_i ? prod_neg : prod;
    end
  end

endmodule

// File: rtl/alu_muldiv_unit.sv
// rtl/alu_muldiv_unit.sv - iterative multiply/divide unit owning HI/LO
module alu_muldiv_unit
  import alu_structure_pkg::*;
#(
  parameter int               WIDTH     = MD_WIDTH,
  parameter int               CNT_W     = $clog2(WIDTH) + 1,
  parameter logic [WIDTH-1:0] DIV0_QUOT = {WIDTH{1'b1}}
) (
  input logic              clock,
  input logic              reset,
  alu_muldiv_unit_if.slave md
);

  md_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q;
  logic             is_div_q, div0_q, neg_res_q, neg_a_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;

  logic [WIDTH-1:0] step_hi_d, step_lo_d, fix_hi_d, fix_lo_d;
  logic             accept, signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign accept    = (state_q == S_IDLE) && md.start && !md.EX_Stall && !md.EX_Flush;
  assign signed_op = (md.op == MD_MULT) || (md.op == MD_DIV);
  assign a_neg     = signed_op && md.A[WIDTH-1];
  assign b_neg     = signed_op && md.B[WIDTH-1];
  assign a_mag     = a_neg ? -md.A : md.A;
  assign b_mag     = b_neg ? -md.B : md.B;

  muldiv_datapath #(
    .WIDTH     (WIDTH),
    .DIV0_QUOT (DIV0_QUOT)
  ) u_datapath (
    .is_div_i  (is_div_q),
    .div0_i    (div0_q),
    .neg_res_i (neg_res_q),
    .neg_a_i   (neg_a_q),
    .acc_hi_i  (acc_hi_q),
    .acc_lo_i  (acc_lo_q),
    .opnd_i    (opnd_q),
    .step_hi_o (step_hi_d),
    .step_lo_o (step_lo_d),
    .fix_hi_o  (fix_hi_d),
    .fix_lo_o  (fix_lo_d)
  );

  // Control FSM: command capture, iteration with stall/flush, HI/LO commit
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      div0_q    <= 1'b0;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            case (md.op)
              MD_MTHI: begin
                hi_q   <= md.A;
                done_q <= 1'b1;
              end
              MD_MTLO: begin
                lo_q   <= md.A;
                done_q <= 1'b1;
              end
              MD_MULT, MD_MULTU: begin
                acc_hi_q  <= '0;
                acc_lo_q  <= b_mag;
                opnd_q    <= a_mag;
                is_div_q  <= 1'b0;
                div0_q    <= 1'b0;
                neg_res_q <= a_neg ^ b_neg;
                neg_a_q   <= a_neg;
                cnt_q     <= '0;
                state_q   <= S_MUL;
              end
              MD_DIV, MD_DIVU: begin
                acc_hi_q  <= '0;
                opnd_q    <= b_mag;
                is_div_q  <= 1'b1;
                neg_res_q <= a_neg ^ b_neg;
                neg_a_q   <= a_neg;
                cnt_q     <= '0;
                // Zero divisor skips iteration; the raw dividend rides in acc_lo to become HI
                if (md.B == '0) begin
                  div0_q   <= 1'b1;
                  acc_lo_q <= md.A;
                  state_q  <= S_FIXUP;
                end else begin
                  div0_q   <= 1'b0;
                  acc_lo_q <= a_mag;
                  state_q  <= S_DIV;
                end
              end
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          if (md.EX_Flush) begin
            state_q <= S_IDLE;
          end else if (!md.EX_Stall) begin
            acc_hi_q <= step_hi_d;
            acc_lo_q <= step_lo_d;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              state_q <= S_FIXUP;
            end
          end
        end
        S_FIXUP: begin
          if (md.EX_Flush) begin
            state_q <= S_IDLE;
          end else if (!md.EX_Stall) begin
            hi_q    <= fix_hi_d;
            lo_q    <= fix_lo_d;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign md.HI   = hi_q;
  assign md.LO   = lo_q;
  assign md.busy = (state_q != S_IDLE);
  assign md.done = done_q;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// tb/tb_alu_muldiv_unit.sv - self-checking bench for alu_muldiv_unit
module tb_alu_muldiv_unit;
  import alu_structure_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   compared = 0;
  int   mismatched = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  alu_muldiv_unit_if #(.WIDTH(32)) md_if ();

  alu_muldiv_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .md    (md_if)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Architectural reference: plain 64-bit arithmetic on the operands
  task automatic model(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] hi, inout logic [31:0] lo);
    longint          sp, sq, sr;
    longint unsigned up, uq, ur;
    case (op)
      MD_MTHI:  hi = a;
      MD_MTLO:  lo = a;
      MD_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        hi = sp[63:32]; lo = sp[31:0];
      end
      MD_MULTU: begin
        up = 64'(a) * 64'(b);
        hi = up[63:32]; lo = up[31:0];
      end
      MD_DIV: begin
        if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          hi = sr[31:0]; lo = sq[31:0];
        end
      end
      default: begin
        if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin
          uq = 64'(a) / 64'(b);
          ur = 64'(a) % 64'(b);
          hi = ur[31:0]; lo = uq[31:0];
        end
      end
    endcase
  endtask

  task automatic run_and_check(input string tag, input muldiv_op_t op,
                               input logic [31:0] a, input logic [31:0] b,
                               input int stall_at, input int stall_len, input int flush_at,
                               input int pulse_at, input int reset_at,
                               input int exp_lat, input int exp_busy);
    logic [31:0] e_hi, e_lo;
    int lat, busy_cyc;
    bit hold_ok;
    e_hi = m_hi; e_lo = m_lo;
    if (flush_at == 0 && reset_at == 0) model(op, a, b, e_hi, e_lo);
    lat = 0; busy_cyc = 0; hold_ok = 1'b1;
    @(negedge clock);
    md_if.start = 1'b1; md_if.op = op; md_if.A = a; md_if.B = b;
    @(negedge clock);
    md_if.start = 1'b0; md_if.A = $urandom; md_if.B = $urandom;
    for (int n = 1; n <= 80; n++) begin
      if (md_if.busy) busy_cyc++;
      if (md_if.busy && (md_if.HI !== m_hi || md_if.LO !== m_lo)) hold_ok = 1'b0;
      if (md_if.done) begin lat = n; break; end
      md_if.EX_Stall = (stall_len > 0 && n >= stall_at && n < stall_at + stall_len);
      md_if.EX_Flush = (n == flush_at);
      md_if.start    = (n == pulse_at);
      if (n == pulse_at) begin md_if.op = MD_MTHI; md_if.A = 32'hDEAD_BEEF; end
      reset = (n == reset_at);
      @(negedge clock);
      if (n == reset_at) break;
    end
    md_if.EX_Stall = 1'b0; md_if.EX_Flush = 1'b0; md_if.start = 1'b0; reset = 1'b0;
    if (reset_at != 0) begin
      check({tag, "_rst_hi"},   64'(md_if.HI),   64'(0));
      check({tag, "_rst_lo"},   64'(md_if.LO),   64'(0));
      check({tag, "_rst_busy"}, 64'(md_if.busy), 64'(0));
      check({tag, "_rst_done"}, 64'(md_if.done), 64'(0));
      m_hi = '0; m_lo = '0;
    end else begin
      check({tag, "_hi"},   64'(md_if.HI), 64'(e_hi));
      check({tag, "_lo"},   64'(md_if.LO), 64'(e_lo));
      check({tag, "_lat"},  64'(lat),      64'(exp_lat));
      check({tag, "_busy"}, 64'(busy_cyc), 64'(exp_busy));
      check({tag, "_hold"}, 64'(hold_ok),  64'(1));
      m_hi = e_hi; m_lo = e_lo;
    end
  endtask

  initial begin
    muldiv_op_t ops [6];
    muldiv_op_t op;
    logic [31:0] a, b;
    bit long_op, div0;
    int sl;
    ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO};

    md_if.start = 1'b0; md_if.op = MD_MULT; md_if.A = '0; md_if.B = '0;
    md_if.EX_Stall = 1'b0; md_if.EX_Flush = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_hi",   64'(md_if.HI),   64'(0));
    check("reset_lo",   64'(md_if.LO),   64'(0));
    check("reset_busy", 64'(md_if.busy), 64'(0));
    check("reset_done", 64'(md_if.done), 64'(0));

    // Start in IDLE is refused while flush or stall is high
    md_if.start = 1'b1; md_if.op = MD_MTHI; md_if.A = 32'h5555_5555; md_if.EX_Flush = 1'b1;
    @(negedge clock);
    md_if.EX_Flush = 1'b0; md_if.EX_Stall = 1'b1;
    check("idle_flush_done", 64'(md_if.done), 64'(0));
    check("idle_flush_hi",   64'(md_if.HI),   64'(m_hi));
    @(negedge clock);
    md_if.start = 1'b0; md_if.EX_Stall = 1'b0;
    check("idle_stall_done", 64'(md_if.done), 64'(0));
    check("idle_stall_hi",   64'(md_if.HI),   64'(m_hi));

    run_and_check("mult_7_m3",   MD_MULT,  32'd7,          32'hFFFF_FFFD, 0, 0, 0, 0, 0, 34, 33);
    check("mult_7_m3_const_lo", 64'(md_if.LO), 64'(32'hFFFF_FFEB));
    run_and_check("multu_max",   MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 34, 33);
    run_and_check("div_m7_2",    MD_DIV,   32'hFFFF_FFF9, 32'd2,         0, 0, 0, 0, 0, 34, 33);
    check("div_m7_2_const_hi", 64'(md_if.HI), 64'(32'hFFFF_FFFF));
    run_and_check("divu_by0",    MD_DIVU,  32'd100,       32'd0,         0, 0, 0, 0, 0, 2, 1);
    run_and_check("div_min_m1",  MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 34, 33);
    run_and_check("mthi",        MD_MTHI,  32'h0000_1234, 32'd0,         0, 0, 0, 0, 0, 1, 0);
    run_and_check("multu_stall", MD_MULTU, 32'd3,         32'd5,         10, 5, 0, 20, 0, 39, 38);
    run_and_check("mtlo",        MD_MTLO,  32'h0000_AAAA, 32'd0,         0, 0, 0, 0, 0, 1, 0);
    run_and_check("div_flush",   MD_DIV,   32'd9,         32'd2,         0, 0, 10, 0, 0, 0, 10);
    check("div_flush_const_lo", 64'(md_if.LO), 64'(32'h0000_AAAA));
    run_and_check("mult_reset",  MD_MULT,  32'd123,       32'd456,       0, 0, 0, 0, 20, 0, 0);
    run_and_check("mult_2_3",    MD_MULT,  32'd2,         32'd3,         0, 0, 0, 0, 0, 34, 33);

    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 5)];
      a  = $urandom;
      b  = $urandom;
      if (i % 7 == 3) b = '0;
      if (i % 11 == 5) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (i % 5 == 1) b = b >> $urandom_range(8, 31);
      long_op = (op inside {MD_MULT, MD_MULTU}) || ((op inside {MD_DIV, MD_DIVU}) && b != 0);
      div0    = (op inside {MD_DIV, MD_DIVU}) && b == 0;
      sl      = long_op ? $urandom_range(0, 3) : 0;
      run_and_check("rand", op, a, b, $urandom_range(2, 30), sl, 0, 0, 0,
                    long_op ? 34 + sl : (div0 ? 2 : 1),
                    long_op ? 33 + sl : (div0 ? 1 : 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
